// File: rtl/knap_stream_eval.sv
// knap_stream_eval: folds N_ITEMS item beats into saturating value/weight/volume totals and presents a verdict the cycle after the last beat; item_ready is low while the verdict waits.
// Optional macro KNAP_BEST_TRACK_EN adds best_found/best_value/best_id, tracking the highest-value accepted candidate.
module knap_stream_eval #(
  parameter int N_ITEMS = 18,
  parameter int COEF_W  = 8,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  cfg_min_value,
  input  logic [ACC_W-1:0]  cfg_max_weight,
  input  logic [ACC_W-1:0]  cfg_max_volume,
  input  logic              item_valid,
  output logic              item_ready,
  input  logic              item_sel,
  input  logic [COEF_W-1:0] item_value,
  input  logic [COEF_W-1:0] item_weight,
  input  logic [COEF_W-1:0] item_volume,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_ok,
  output logic [ACC_W-1:0]  res_value,
  output logic [ACC_W-1:0]  res_weight,
  output logic [ACC_W-1:0]  res_volume,
  output logic              res_sat,
`ifdef KNAP_BEST_TRACK_EN
  output logic              best_found,
  output logic [ACC_W-1:0]  best_value,
  output logic [15:0]       best_id,
`endif
  output logic [15:0]       res_id
);

  localparam int CNT_W = $clog2(N_ITEMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITEMS - 1);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] thr_min, thr_weight, thr_volume;
  logic [ACC_W-1:0] tot_value, tot_weight, tot_volume;
  logic             sat_value, sat_weight, sat_volume;
  logic [ACC_W:0]   add_value, add_weight, add_volume;
  logic             accept, verdict;

  // Top bit of the result is the overflow flag; low bits are already clamped.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [COEF_W-1:0] coef);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - COEF_W){1'b0}}, coef};
    return sum[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : sum;
  endfunction

  assign item_ready = (state == ACCUM);
  assign res_valid  = (state == REPORT);
  assign accept     = item_valid && item_ready;

  always_comb begin
    add_value  = {1'b0, tot_value};
    add_weight = {1'b0, tot_weight};
    add_volume = {1'b0, tot_volume};
    if (item_sel) begin
      add_value  = sat_add(tot_value, item_value);
      add_weight = sat_add(tot_weight, item_weight);
      add_volume = sat_add(tot_volume, item_volume);
    end
    // Only consulted on the last beat, so thresholds are always the captured ones.
    verdict = (add_value[ACC_W-1:0] >= thr_min) &&
              (add_weight[ACC_W-1:0] <= thr_weight) &&
              (add_volume[ACC_W-1:0] <= thr_volume) &&
              !(sat_weight || add_weight[ACC_W]) &&
              !(sat_volume || add_volume[ACC_W]);
  end

  assign res_value  = tot_value;
  assign res_weight = tot_weight;
  assign res_volume = tot_volume;
  assign res_sat    = sat_value || sat_weight || sat_volume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      cnt        <= '0;
      thr_min    <= '0;
      thr_weight <= '0;
      thr_volume <= '0;
      tot_value  <= '0;
      tot_weight <= '0;
      tot_volume <= '0;
      sat_value  <= 1'b0;
      sat_weight <= 1'b0;
      sat_volume <= 1'b0;
      res_ok     <= 1'b0;
      res_id     <= '0;
`ifdef KNAP_BEST_TRACK_EN
      best_found <= 1'b0;
      best_value <= '0;
      best_id    <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt == '0) begin
              thr_min    <= cfg_min_value;
              thr_weight <= cfg_max_weight;
              thr_volume <= cfg_max_volume;
            end
            tot_value  <= add_value[ACC_W-1:0];
            tot_weight <= add_weight[ACC_W-1:0];
            tot_volume <= add_volume[ACC_W-1:0];
            sat_value  <= sat_value || add_value[ACC_W];
            sat_weight <= sat_weight || add_weight[ACC_W];
            sat_volume <= sat_volume || add_volume[ACC_W];
            if (cnt == LAST) begin
              cnt    <= '0;
              res_ok <= verdict;
              state  <= REPORT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
`ifdef KNAP_BEST_TRACK_EN
            // Strict greater-than keeps the earlier candidate on ties.
            if (res_ok && (!best_found || tot_value > best_value)) begin
              best_found <= 1'b1;
              best_value <= tot_value;
              best_id    <= res_id;
            end
`endif
            tot_value  <= '0;
            tot_weight <= '0;
            tot_volume <= '0;
            sat_value  <= 1'b0;
            sat_weight <= 1'b0;
            sat_volume <= 1'b0;
            res_ok     <= 1'b0;
            res_id     <= res_id + 16'd1;
            state      <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_knap_stream_eval.sv
// Randomized bench for knap_stream_eval (N_ITEMS=4, ACC_W=9) against a plain-arithmetic candidate model.
module tb_knap_stream_eval;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int AW = 9;
  localparam int MAXACC = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_min_value, cfg_max_weight, cfg_max_volume;
  logic          item_valid, item_ready, item_sel;
  logic [CW-1:0] item_value, item_weight, item_volume;
  logic          res_valid, res_ready, res_ok, res_sat;
  logic [AW-1:0] res_value, res_weight, res_volume;
  logic [15:0]   res_id;
`ifdef KNAP_BEST_TRACK_EN
  logic          best_found;
  logic [AW-1:0] best_value;
  logic [15:0]   best_id;
`endif

  always #5 clk = ~clk;

  knap_stream_eval #(.N_ITEMS(N), .COEF_W(CW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_min_value(cfg_min_value), .cfg_max_weight(cfg_max_weight), .cfg_max_volume(cfg_max_volume),
    .item_valid(item_valid), .item_ready(item_ready), .item_sel(item_sel),
    .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
    .res_value(res_value), .res_weight(res_weight), .res_volume(res_volume),
    .res_sat(res_sat),
`ifdef KNAP_BEST_TRACK_EN
    .best_found(best_found), .best_value(best_value), .best_id(best_id),
`endif
    .res_id(res_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Candidate model state
  bit it_sel [N];
  int it_v [N], it_w [N], it_vol [N];
  int thr_min, thr_w, thr_vol;
  int exp_id;
  bit m_best_found;
  int m_best_val, m_best_id;

  task automatic set_cfg(input int mn, input int mw, input int mv);
    cfg_min_value  = AW'(mn);
    cfg_max_weight = AW'(mw);
    cfg_max_volume = AW'(mv);
  endtask

  task automatic send_beat(input int i);
    int t = 0;
    item_sel    = it_sel[i];
    item_value  = CW'(it_v[i]);
    item_weight = CW'(it_w[i]);
    item_volume = CW'(it_vol[i]);
    item_valid  = 1'b1;
    while (!item_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("beat_timeout", 0, 1);
    @(negedge clk);
    item_valid = 1'b0;
  endtask

  // Thresholds for the model are whatever cfg holds when beat 0 goes in.
  task automatic run_items(input bit twiddle);
    thr_min = int'(cfg_min_value);
    thr_w   = int'(cfg_max_weight);
    thr_vol = int'(cfg_max_volume);
    for (int i = 0; i < N; i++) begin
      send_beat(i);
      if (twiddle && i == 1)
        set_cfg($urandom_range(0, MAXACC), $urandom_range(0, MAXACC), $urandom_range(0, MAXACC));
    end
  endtask

  task automatic collect(input string tag, input int stall, input bit hold_valid);
    int sv = 0, sw = 0, svol = 0, ev, ew, evol, t = 0;
    bit es, eok;
    for (int i = 0; i < N; i++)
      if (it_sel[i]) begin
        sv += it_v[i]; sw += it_w[i]; svol += it_vol[i];
      end
    ev   = (sv > MAXACC) ? MAXACC : sv;
    ew   = (sw > MAXACC) ? MAXACC : sw;
    evol = (svol > MAXACC) ? MAXACC : svol;
    es   = (sv > MAXACC) || (sw > MAXACC) || (svol > MAXACC);
    eok  = (ev >= thr_min) && (ew <= thr_w) && (evol <= thr_vol) && !(sw > MAXACC) && !(svol > MAXACC);
    while (!res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({tag, "_res_timeout"}, 0, 1);
    if (hold_valid) begin
      item_valid = 1'b1; item_sel = 1'b1;
      item_value = 8'd200; item_weight = 8'd200; item_volume = 8'd200;
    end
    for (int s = 0; s <= stall; s++) begin
      check({tag, "_ok"}, res_ok, eok);
      check({tag, "_val"}, res_value, ev);
      check({tag, "_wt"}, res_weight, ew);
      check({tag, "_vol"}, res_volume, evol);
      check({tag, "_sat"}, res_sat, es);
      check({tag, "_id"}, res_id, exp_id);
      check({tag, "_irdy_lo"}, item_ready, 0);
      if (s < stall) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready  = 1'b0;
    check({tag, "_irdy_back"}, item_ready, 1);
    check({tag, "_rvld_lo"}, res_valid, 0);
    item_valid = 1'b0;
    if (eok && (!m_best_found || ev > m_best_val)) begin
      m_best_found = 1'b1; m_best_val = ev; m_best_id = exp_id;
    end
    exp_id = (exp_id + 1) % 65536;
`ifdef KNAP_BEST_TRACK_EN
    check({tag, "_bfound"}, best_found, m_best_found);
    check({tag, "_bval"}, best_value, m_best_val);
    check({tag, "_bid"}, best_id, m_best_id);
`endif
  endtask

  task automatic fill(input int i, input bit s, input int v, input int w, input int vol);
    it_sel[i] = s; it_v[i] = v; it_w[i] = w; it_vol[i] = vol;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_irdy", item_ready, 1);
    check("rst_rvld", res_valid, 0);
    check("rst_ok", res_ok, 0);
    check("rst_totals", {res_value, res_weight, res_volume}, 0);
    check("rst_sat", res_sat, 0);
    check("rst_id", res_id, 0);
    exp_id = 0; m_best_found = 0; m_best_val = 0; m_best_id = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_irdy_after", item_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; item_valid = 1'b0; res_ready = 1'b0;
    item_sel = 1'b0; item_value = '0; item_weight = '0; item_volume = '0;
    set_cfg(0, 0, 0);
    exp_id = 0;
    do_reset();

    // Three 10/10/10 items plus a deselected one
    set_cfg(30, 40, 40);
    for (int i = 0; i < 3; i++) fill(i, 1, 10, 10, 10);
    fill(3, 0, 99, 99, 99);
    run_items(0);
    collect("basic", 0, 0);

    // Weight overshoots by one
    fill(3, 1, 5, 11, 0);
    run_items(0);
    collect("overweight", 0, 0);

    // Weight saturation forces a fail even at the maximum limit
    set_cfg(0, MAXACC, MAXACC);
    for (int i = 0; i < N; i++) fill(i, 1, 1, 255, 1);
    run_items(0);
    collect("wsat", 0, 0);

    // Value saturation alone does not fail the candidate
    for (int i = 0; i < N; i++) fill(i, 1, 255, 1, 1);
    set_cfg(MAXACC, 10, 10);
    run_items(0);
    collect("vsat", 0, 0);

    // Long stall with a beat waiting
    set_cfg(30, 40, 40);
    for (int i = 0; i < N; i++) fill(i, 1, 10, 10, 10);
    run_items(0);
    collect("stall", 10, 1);
    for (int i = 0; i < N; i++) fill(i, 1, 3, 4, 5);
    run_items(0);
    collect("after_stall", 0, 0);

    // Threshold change after item 1 is ignored
    set_cfg(30, 40, 40);
    for (int i = 0; i < N; i++) fill(i, 1, 10, 5, 5);
    thr_min = 30; thr_w = 40; thr_vol = 40;
    send_beat(0); send_beat(1);
    set_cfg(100, 40, 40);
    send_beat(2); send_beat(3);
    collect("cfg_hold", 0, 0);

    // Reset after item 2 discards the partial candidate
    set_cfg(0, MAXACC, MAXACC);
    for (int i = 0; i < N; i++) fill(i, 1, 200, 200, 200);
    send_beat(0); send_beat(1); send_beat(2);
    do_reset();
    for (int i = 0; i < N; i++) fill(i, 1, 7, 8, 9);
    run_items(0);
    collect("post_rst", 0, 0);

`ifdef KNAP_BEST_TRACK_EN
    do_reset();
    set_cfg(0, 100, 100);
    for (int c = 0; c < 4; c++) begin
      int vals [4] = '{30, 45, 45, 90};
      for (int i = 0; i < N; i++) fill(i, i == 0, vals[c], (c == 3) ? 150 : 10, 10);
      run_items(0);
      collect($sformatf("best%0d", c), 0, 0);
    end
    check("best_found_final", best_found, 1);
    check("best_value_final", best_value, 45);
    check("best_id_final", best_id, 1);
`endif

    // Randomized candidates
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        fill(i, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 100),
             ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 100),
             ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 100));
      set_cfg($urandom_range(0, 250), $urandom_range(50, MAXACC), $urandom_range(50, MAXACC));
      run_items($urandom_range(0, 1) == 1);
      collect($sformatf("rnd%0d", c), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/knap_stream_eval.md
KNAP_STREAM_EVAL -- requirements
Module: knap_stream_eval

Interface
REQ-001 Parameter N_ITEMS, default 18, number of items per candidate selection (2..256).
REQ-002 Parameter COEF_W, default 8, width of each per-item value/weight/volume coefficient.
REQ-003 Parameter ACC_W, default 12, width of accumulators, thresholds and result totals (ACC_W >= COEF_W+1).
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port cfg_min_value, cfg_max_weight, cfg_max_volume  in  ACC_W each  candidate acceptance thresholds.
REQ-007 Port item_valid  in  1  item beat present; item_ready  out  1  block can accept a beat.
REQ-008 Port item_sel  in  1  item chosen in this candidate; item_value, item_weight, item_volume  in  COEF_W each  item coefficients.
REQ-009 Port res_valid  out  1  verdict present; res_ready  in  1  downstream takes verdict.
REQ-010 Port res_ok  out  1  candidate meets all three constraints; res_value, res_weight, res_volume  out  ACC_W each  totals; res_sat  out  1  any total saturated; res_id  out  16  candidate sequence number.

Function
REQ-011 Two states SHALL exist: ACCUM (item_ready=1, res_valid=0) and REPORT (item_ready=0, res_valid=1).
REQ-012 A beat SHALL be accepted only when item_valid && item_ready; item_sel=0 beats SHALL advance the item counter without changing totals.
REQ-013 Item counter SHALL run 0..N_ITEMS-1; acceptance at N_ITEMS-1 SHALL move ACCUM->REPORT, res_valid asserting the cycle after that beat.
REQ-014 Thresholds SHALL be captured on acceptance of item 0 and held for that candidate; cfg changes mid-candidate SHALL NOT affect the verdict.
REQ-015 Each total SHALL add the zero-extended coefficient and saturate at 2^ACC_W-1, setting a per-candidate sticky saturation flag; res_sat = OR of the three flags.
REQ-016 res_ok SHALL equal (value >= min) && (weight <= max_weight) && (volume <= max_volume) && !weight_sat && !volume_sat, all comparisons unsigned.
REQ-017 Value saturation SHALL NOT force res_ok low.
REQ-018 res_* outputs SHALL remain stable while res_valid && !res_ready.
REQ-019 On res_valid && res_ready: return to ACCUM next cycle, totals, flags and counter cleared, res_id incremented (wraps 0xFFFF->0); item_ready SHALL NOT assert in the handshake cycle itself.
REQ-020 No combinational path SHALL exist from any input to item_ready or res_valid.

Reset
REQ-021 rst_n low SHALL immediately force state ACCUM, counter 0, totals 0, saturation flags 0, res_id 0, res_valid 0, res_ok 0, res_value/weight/volume 0, res_sat 0.
REQ-022 Reset asserted mid-candidate or during REPORT SHALL discard the partial candidate/pending verdict; item_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-023 Macro KNAP_BEST_TRACK_EN, when defined, SHALL add outputs best_found (1), best_value (ACC_W), best_id (16), reset to 0.
REQ-024 With KNAP_BEST_TRACK_EN: on each verdict handshake with res_ok=1 and (best_found=0 or res_value > best_value), update best_value/best_id, set best_found; ties keep the earlier candidate.
REQ-025 Without KNAP_BEST_TRACK_EN the three ports and their registers SHALL be absent; all other behaviour identical.

Verification
REQ-026 N_ITEMS=4, thresholds min=30/maxW=40/maxV=40, items sel=1 (v,w,vol)=(10,10,10)x3 + sel=0 -> res_ok=1, totals 30/30/30, res_id=0.
REQ-027 Same thresholds, fourth item sel=1 (5,11,0) -> weight 41, res_ok=0, res_sat=0.
REQ-028 ACC_W=9, COEF_W=8, four items weight 255 -> res_weight=511, res_sat=1, res_ok=0 even with max_weight=511.
REQ-029 Hold res_ready=0 for 10 cycles with item_valid=1 -> outputs stable, no beats accepted, item_ready=0 until cycle after handshake.
REQ-030 Change cfg_min_value 30->100 after item 1 accepted -> verdict still uses 30; rst_n pulsed after item 2 -> next verdict uses fresh candidate, res_id=0.
REQ-031 KNAP_BEST_TRACK_EN: ok candidates with values 30, 45, 45, failing candidate value 90 -> best_value=45, best_id=1, best_found=1.
